audio_pwm_mixer: RTL and testbench

- Wishbone-mapped, multi-channel PWM audio player; successor to the single-song ROM player.
- The CPU streams unsigned samples into a small FIFO per channel.
- Once per PWM frame the block pops one sample per enabled channel, applies per-channel attenuation, mixes with saturation and drives a single PWM pin.
- Sits on the wishbone peripheral bus beside the game logic. It raises a low-water interrupt so firmware can refill the FIFOs.

---
 rtl/audio_pwm_mixer.sv | 208 ++++++++++++++++++++
 tb/tb_audio_pwm_mixer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_mixer.sv
// Wishbone-mapped multi-channel PWM audio mixer: per-channel sample FIFOs,
// per-frame pop with attenuation, saturating mix and a single PWM output.
module audio_pwm_mixer #(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [7:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        aud_pwm,
    output logic        aud_sd,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = SAMPLE_W;
    localparam logic [SW-1:0]        MID      = SW'(1 << (SW - 1));
    localparam logic signed [SW+2:0] MID_S    = (SW+3)'(1 << (SW - 1));
    localparam logic signed [SW+2:0] NEG_LIM  = -MID_S;
    localparam logic signed [SW+2:0] POS_LIM  = MID_S - 1;
    localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]          LOW_CNT  = (AW+1)'(LOW_WATER);

    logic                 ack, en, irq_en, mix_pending, pwm_q, irq_q;
    logic [NUM_CH-1:0]    ch_mask, underrun, overflow, empty, full, low;
    logic [NUM_CH-1:0]    push_ok, pop_ok, overflow_set, underrun_set;
    logic [NUM_CH-1:0]    clr_under, clr_over;
    logic [DIV_W-1:0]     prescale, pres;
    logic [3*NUM_CH-1:0]  vol;
    logic [SW-1:0]        cnt, duty, mix_reg, mix_next;
    logic [SW-1:0]        samp_q [NUM_CH];
    logic [SW-1:0]        mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr [NUM_CH];
    logic [AW-1:0]        wr_ptr [NUM_CH];
    logic [AW:0]          count [NUM_CH];
    logic [3:0]           widx;
    logic                 wr, wr_ctrl, wr_status, flush, tick, boundary;
    logic signed [SW+2:0] sum, term;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign widx      = wb_adr_i[5:2];
    assign wr        = ack & wb_we_i;
    assign wr_ctrl   = wr && (widx == 4'd0);
    assign wr_status = wr && (widx == 4'd2);
    assign flush     = wr_ctrl & wb_dat_i[31];
    assign tick      = en && (pres == prescale);
    assign boundary  = tick && (cnt == {SW{1'b1}});
    assign clr_under = wr_status ? wb_dat_i[16 +: NUM_CH] : '0;
    assign clr_over  = wr_status ? wb_dat_i[24 +: NUM_CH] : '0;
    assign unused_bits = ^{wb_adr_i[7:6], wb_adr_i[1:0], wb_dat_i};

    assign wb_ack_o = ack;
    assign wb_dat_o = rdata;
    assign aud_pwm  = pwm_q;
    assign aud_sd   = en;
    assign irq_o    = irq_q;

    always_comb begin
        empty        = '0;
        full         = '0;
        low          = '0;
        push_ok      = '0;
        pop_ok       = '0;
        overflow_set = '0;
        underrun_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]        = (count[c] == '0);
            full[c]         = (count[c] == FULL_CNT);
            low[c]          = (count[c] <= LOW_CNT);
            push_ok[c]      = wr && (widx == 4'(4 + c)) && !full[c] && !flush;
            overflow_set[c] = wr && (widx == 4'(4 + c)) && full[c];
            pop_ok[c]       = boundary && ch_mask[c] && !empty[c] && !flush;
            underrun_set[c] = boundary && ch_mask[c] && empty[c];
        end
    end

    // Centre each latched sample, attenuate, sum wide, then clamp before re-biasing.
    always_comb begin
        sum  = '0;
        term = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            term = $signed({3'b000, samp_q[c]}) - MID_S;
            term = term >>> vol[3*c +: 3];
            sum  = sum + term;
        end
        if (sum > POS_LIM)
            mix_next = '1;
        else if (sum < NEG_LIM)
            mix_next = '0;
        else
            mix_next = SW'(sum + MID_S);
    end

    always_comb begin
        rdata = '0;
        case (widx)
            4'd0: begin
                rdata[0]            = en;
                rdata[8 +: NUM_CH]  = ch_mask;
                rdata[16]           = irq_en;
            end
            4'd1: rdata[DIV_W-1:0] = prescale;
            4'd2: begin
                rdata[0 +: NUM_CH]  = empty;
                rdata[8 +: NUM_CH]  = full;
                rdata[16 +: NUM_CH] = underrun;
                rdata[24 +: NUM_CH] = overflow;
            end
            4'd3: rdata[3*NUM_CH-1:0] = vol;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push_ok[c])
                mem[c][wr_ptr[c]] <= wb_dat_i[SW-1:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack         <= 1'b0;
            en          <= 1'b0;
            irq_en      <= 1'b0;
            ch_mask     <= '0;
            prescale    <= '0;
            vol         <= '0;
            underrun    <= '0;
            overflow    <= '0;
            pres        <= '0;
            cnt         <= '0;
            duty        <= MID;
            mix_reg     <= MID;
            mix_pending <= 1'b0;
            pwm_q       <= 1'b0;
            irq_q       <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                samp_q[c] <= MID;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            ack <= wb_stb_i & wb_cyc_i & ~ack;
            if (wr_ctrl) begin
                en      <= wb_dat_i[0];
                ch_mask <= wb_dat_i[8 +: NUM_CH];
                irq_en  <= wb_dat_i[16];
            end
            if (wr && (widx == 4'd1))
                prescale <= wb_dat_i[DIV_W-1:0];
            if (wr && (widx == 4'd3))
                vol <= wb_dat_i[3*NUM_CH-1:0];
            underrun <= (underrun & ~clr_under) | underrun_set;
            overflow <= (overflow & ~clr_over) | overflow_set;

            // While disabled the frame timing parks at zero with a silent midpoint duty.
            if (!en) begin
                pres <= '0;
                cnt  <= '0;
                duty <= MID;
            end else if (tick) begin
                pres <= '0;
                cnt  <= cnt + 1'b1;
                if (boundary)
                    duty <= mix_reg;
            end else begin
                pres <= pres + 1'b1;
            end

            if (boundary)
                for (int c = 0; c < NUM_CH; c++)
                    samp_q[c] <= pop_ok[c] ? mem[c][rd_ptr[c]] : MID;
            mix_pending <= boundary;
            if (mix_pending)
                mix_reg <= mix_next;

            for (int c = 0; c < NUM_CH; c++) begin
                if (flush) begin
                    rd_ptr[c] <= '0;
                    wr_ptr[c] <= '0;
                    count[c]  <= '0;
                end else begin
                    if (push_ok[c])
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (pop_ok[c])
                        rd_ptr[c] <= rd_ptr[c] + 1'b1;
                    if (push_ok[c] && !pop_ok[c])
                        count[c] <= count[c] + 1'b1;
                    else if (pop_ok[c] && !push_ok[c])
                        count[c] <= count[c] - 1'b1;
                end
            end

            pwm_q <= en & (cnt < duty);
            irq_q <= irq_en & (|(ch_mask & low));
        end
    end
endmodule

// File: tb/tb_audio_pwm_mixer.sv
// Self-checking bench for audio_pwm_mixer: measures PWM high time per frame and
// compares it, plus STATUS/IRQ, against a frame-level model of queued samples.
module tb_audio_pwm_mixer;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int MIDV  = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [7:0]  adr = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        ack, pwm, sd, irq;

    int n_checks = 0;
    int n_pass = 0;
    int push_n [NCH];
    int push_s [NCH][20];

    audio_pwm_mixer dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .aud_pwm  (pwm),
        .aud_sd   (sd),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        @(posedge clk); #1;
        checkOutput("ack_wr", ack, 1);
        @(posedge clk); #1;
        checkOutput("ack_single", ack, 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk); #1;
        checkOutput("ack_rd", ack, 1);
        d = dat_r;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    // Duty expected after boundary f has popped its samples (f = boundary index).
    function automatic int mix_of(input int f, input int msk, input int vl, input int kept[NCH]);
        int sum, smp, t;
        sum = 0;
        for (int c = 0; c < NCH; c++) begin
            smp = (((msk >> c) & 1) == 1 && f < kept[c]) ? push_s[c][f] : MIDV;
            t = (smp - MIDV) >>> ((vl >> (3 * c)) & 7);
            sum += t;
        end
        if (sum > 127) sum = 127;
        if (sum < -128) sum = -128;
        return sum + MIDV;
    endfunction

    function automatic int remaining(input int c, input int nb, input int msk, input int kept[NCH]);
        int popped;
        popped = (((msk >> c) & 1) == 1) ? ((nb < kept[c]) ? nb : kept[c]) : 0;
        return kept[c] - popped;
    endfunction

    function automatic logic [31:0] status_exp(input int nb, input int msk, input int kept[NCH], input bit flags);
        logic [31:0] s;
        int r;
        s = '0;
        for (int c = 0; c < NCH; c++) begin
            r = remaining(c, nb, msk, kept);
            s[c]     = (r == 0);
            s[8 + c] = (r == DEPTH);
            if (flags) begin
                s[16 + c] = (((msk >> c) & 1) == 1) && (nb > kept[c]);
                s[24 + c] = (push_n[c] > DEPTH);
            end
        end
        return s;
    endfunction

    function automatic int irq_exp(input int nb, input int msk, input int irqe, input int kept[NCH]);
        int any;
        any = 0;
        for (int c = 0; c < NCH; c++)
            if ((((msk >> c) & 1) == 1) && remaining(c, nb, msk, kept) <= 4)
                any = 1;
        return irqe & any;
    endfunction

    task automatic measure_frame(input int len, output int highs);
        highs = 0;
        repeat (len) begin
            @(posedge clk); #1;
            highs += int'(pwm);
        end
    endtask

    task automatic applyStimulus(input string name, input int nfr, input int pre,
                                 input int msk, input int vl, input int irqe);
        int kept[NCH];
        int len, highs, exp_duty;
        logic [31:0] ctrl, st;
        len = 256 * (pre + 1);
        do_reset();
        bus_write(8'h04, 32'(pre));
        bus_write(8'h0C, 32'(vl));
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < push_n[c]; i++)
                bus_write(8'((4 + c) * 4), 32'(push_s[c][i]));
            kept[c] = (push_n[c] > DEPTH) ? DEPTH : push_n[c];
        end
        bus_read(8'h08, st);
        checkOutput({name, "_status_fill"}, st, status_exp(0, msk, kept, 1'b1));

        ctrl = 32'(irqe << 16) | 32'(msk << 8);
        bus_write(8'h00, ctrl | 32'h1);
        for (int f = 0; f < nfr; f++) begin
            measure_frame(len, highs);
            exp_duty = (f < 2) ? MIDV : mix_of(f - 2, msk, vl, kept);
            checkOutput($sformatf("%s_frame%0d", name, f), highs, exp_duty * (pre + 1));
        end

        repeat ($urandom_range(0, 100)) @(posedge clk);
        bus_write(8'h00, ctrl);
        @(posedge clk); #1;
        checkOutput({name, "_pwm_off"}, pwm, 0);
        checkOutput({name, "_sd_off"}, sd, 0);
        bus_read(8'h08, st);
        checkOutput({name, "_status_run"}, st, status_exp(nfr, msk, kept, 1'b1));
        checkOutput({name, "_irq_run"}, irq, irq_exp(nfr, msk, irqe, kept));

        bus_write(8'h00, ctrl | 32'h1);
        measure_frame(len, highs);
        checkOutput({name, "_reenable"}, highs, MIDV * (pre + 1));
        bus_write(8'h00, ctrl);
        bus_read(8'h08, st);
        checkOutput({name, "_status_re"}, st, status_exp(nfr + 1, msk, kept, 1'b1));
        checkOutput({name, "_irq_re"}, irq, irq_exp(nfr + 1, msk, irqe, kept));

        bus_write(8'h08, 32'hFFFF_0000);
        bus_read(8'h08, st);
        checkOutput({name, "_w1c"}, st, status_exp(nfr + 1, msk, kept, 1'b0));

        bus_write(8'h00, ctrl | 32'h8000_0000);
        bus_read(8'h08, st);
        checkOutput({name, "_flush"}, st, 32'h3);
        checkOutput({name, "_irq_flush"}, irq, (msk != 0) ? irqe : 0);
        bus_read(8'h00, st);
        checkOutput({name, "_ctrl_rb"}, st, ctrl);
    endtask

    task automatic set_pushes(input int n0, input int n1);
        push_n[0] = n0;
        push_n[1] = n1;
    endtask

    initial begin
        logic [31:0] rd;
        do_reset();

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; dat_w = 32'h1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_pwm", pwm, 0);
        checkOutput("rst_sd", sd, 0);
        checkOutput("rst_irq", irq, 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(8'h08, rd);
        checkOutput("rst_status", rd, 32'h3);

        bus_write(8'h00, 32'h0001_0101);
        bus_write(8'h04, 32'h3);
        bus_write(8'h0C, 32'h8);
        bus_read(8'h00, rd); checkOutput("rb_ctrl", rd, 32'h0001_0101);
        bus_read(8'h04, rd); checkOutput("rb_prescale", rd, 32'h3);
        bus_read(8'h0C, rd); checkOutput("rb_vol", rd, 32'h8);
        bus_read(8'h10, rd); checkOutput("rb_data_wo", rd, 32'h0);
        bus_read(8'h3C, rd); checkOutput("rb_unmapped", rd, 32'h0);

        set_pushes(2, 0);
        push_s[0][0] = 'h40; push_s[0][1] = 'hC0;
        applyStimulus("single", 5, 0, 1, 0, 0);

        set_pushes(1, 1);
        push_s[0][0] = 'hF0; push_s[1][0] = 'hF0;
        applyStimulus("sat_hi", 3, 0, 3, 0, 1);
        applyStimulus("sat_vol", 3, 0, 3, 8, 0);
        push_s[0][0] = 'h10; push_s[1][0] = 'h10;
        applyStimulus("sat_lo", 3, 1, 3, 0, 0);

        set_pushes(17, 0);
        for (int i = 0; i < 17; i++)
            push_s[0][i] = int'($urandom_range(0, 255));
        applyStimulus("ovf", 18, 0, 1, 0, 1);

        for (int s = 0; s < 8; s++) begin
            set_pushes(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < 20; i++)
                    push_s[c][i] = int'($urandom_range(0, 255));
            applyStimulus($sformatf("rnd%0d", s), int'($urandom_range(3, 5)),
                          int'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                          int'($urandom_range(0, 63)), int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
